// File: rtl/sprite_engine_if.sv
// ---------------------------------------------------------------------------
// sprite_engine_if
//
// Read bus between the sprite overlay stage and the external sprite RGB
// memory. The sprite engine is the master: it issues a registered read
// address every pixel clock and the memory returns the {R,G,B} texel a
// fixed number of cycles later. There is no handshake because the pipeline
// never stalls.
//
// Signals:
//   mem_addr  master -> slave  ADDR_W  texel read address
//   mem_rgb   slave -> master  24      {R,G,B} texel returned after MEM_LAT
// ---------------------------------------------------------------------------
interface sprite_engine_if #(
    parameter int ADDR_W = 16
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic [23:0]       mem_rgb;

    modport master (
        output mem_addr,
        input  mem_rgb
    );

    modport slave (
        input  mem_addr,
        output mem_rgb
    );

endinterface

// File: rtl/sprite_engine.sv
// ---------------------------------------------------------------------------
// sprite_engine
//
// Sprite overlay stage for the VGA pipeline. For every raster coordinate it
// decides whether the pixel lies inside a movable, optionally scaled and
// horizontally mirrored sprite window, issues the matching texel address to
// the external sprite memory, and returns either the opaque sprite texel or
// black/transparent to the colour mux. Position and mode are written into
// shadow registers at any time and only copied into the active registers on
// frame_start, so the sprite never tears mid-frame.
//
// Pipeline (constant latency MEM_LAT+2, no stalls):
//   S0  combinational box test and texel address from x/y and active regs
//   S1  registered mem_addr and in_box
//   MEM_LAT-deep in_box delay line, aligned with the memory read latency
//   output register: RGB and hit
//
// Ports:
//   clk          in   1       pixel clock
//   rst          in   1       synchronous active-high reset
//   x, y         in   10      raster coordinate
//   frame_start  in   1       commits shadow regs into active regs
//   pos_we       in   1       loads shadow regs from the *_in inputs
//   pos_x_in     in   10      new X position
//   pos_y_in     in   10      new Y position
//   scale_in     in   2       log2 scale (3 behaves as 2)
//   mirror_in    in   1       horizontal flip
//   enable_in    in   1       sprite visible
//   mem          if   master  texel read bus (mem_addr out, mem_rgb in)
//   VGA_RED      out  8       output red
//   VGA_GREEN    out  8       output green
//   VGA_BLUE     out  8       output blue
//   hit          out  1       output pixel is an opaque sprite texel
// ---------------------------------------------------------------------------
module sprite_engine #(
    parameter int          SPR_W   = 224,
    parameter int          SPR_H   = 180,
    parameter int          ADDR_W  = 16,
    parameter int          MEM_LAT = 1,
    parameter int          INIT_X  = 150,
    parameter int          INIT_Y  = 100,
    parameter logic [23:0] KEY_RGB = 24'hFF00FF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [9:0]             x,
    input  logic [9:0]             y,
    input  logic                   frame_start,
    input  logic                   pos_we,
    input  logic [9:0]             pos_x_in,
    input  logic [9:0]             pos_y_in,
    input  logic [1:0]             scale_in,
    input  logic                   mirror_in,
    input  logic                   enable_in,
    sprite_engine_if.master        mem,
    output logic [7:0]             VGA_RED,
    output logic [7:0]             VGA_GREEN,
    output logic [7:0]             VGA_BLUE,
    output logic                   hit
);

    // Shadow registers (written by pos_we)
    logic [9:0]  sh_pos_x_q, sh_pos_x_d;
    logic [9:0]  sh_pos_y_q, sh_pos_y_d;
    logic [1:0]  sh_scale_q, sh_scale_d;
    logic        sh_mirror_q, sh_mirror_d;
    logic        sh_enable_q, sh_enable_d;

    // Active registers (used by the box test)
    logic [9:0]  act_pos_x_q, act_pos_x_d;
    logic [9:0]  act_pos_y_q, act_pos_y_d;
    logic [1:0]  act_scale_q, act_scale_d;
    logic        act_mirror_q, act_mirror_d;
    logic        act_enable_q, act_enable_d;

    // Pipeline registers
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               in_box_q, in_box_d;
    logic [MEM_LAT-1:0] in_box_dly_q, in_box_dly_d;
    logic [23:0]        rgb_q, rgb_d;
    logic               hit_q, hit_d;

    // S0 intermediates
    logic [1:0]        eff_scale;
    logic [11:0]       spr_w_scaled;
    logic [11:0]       spr_h_scaled;
    logic [11:0]       x_ext, y_ext;
    logic [11:0]       px_ext, py_ext;
    logic [11:0]       far_x, far_y;
    logic              in_box_s0;
    logic [11:0]       dx, dy;
    logic [11:0]       tx_raw, ty_raw;
    logic [11:0]       tx;
    logic [ADDR_W-1:0] tx_a, ty_a;

    // Shadow/active register update. The active copy takes the shadow's
    // next value, so a pos_we coinciding with frame_start goes straight
    // through to the active registers in the same cycle.
    always_comb begin
        sh_pos_x_d  = sh_pos_x_q;
        sh_pos_y_d  = sh_pos_y_q;
        sh_scale_d  = sh_scale_q;
        sh_mirror_d = sh_mirror_q;
        sh_enable_d = sh_enable_q;
        if (pos_we) begin
            sh_pos_x_d  = pos_x_in;
            sh_pos_y_d  = pos_y_in;
            sh_scale_d  = scale_in;
            sh_mirror_d = mirror_in;
            sh_enable_d = enable_in;
        end

        act_pos_x_d  = act_pos_x_q;
        act_pos_y_d  = act_pos_y_q;
        act_scale_d  = act_scale_q;
        act_mirror_d = act_mirror_q;
        act_enable_d = act_enable_q;
        if (frame_start) begin
            act_pos_x_d  = sh_pos_x_d;
            act_pos_y_d  = sh_pos_y_d;
            act_scale_d  = sh_scale_d;
            act_mirror_d = sh_mirror_d;
            act_enable_d = sh_enable_d;
        end
    end

    // S0: box test and texel address. Everything is widened to 12 bits so
    // px+SW cannot wrap (1023 + 224*4 < 4096); a sprite running past the
    // screen edge is simply clipped by the raster range.
    always_comb begin
        eff_scale    = (act_scale_q == 2'd3) ? 2'd2 : act_scale_q;
        spr_w_scaled = 12'(SPR_W) << eff_scale;
        spr_h_scaled = 12'(SPR_H) << eff_scale;
        x_ext        = {2'b00, x};
        y_ext        = {2'b00, y};
        px_ext       = {2'b00, act_pos_x_q};
        py_ext       = {2'b00, act_pos_y_q};
        far_x        = px_ext + spr_w_scaled;
        far_y        = py_ext + spr_h_scaled;

        in_box_s0 = act_enable_q
                 && (x_ext >= px_ext) && (x_ext < far_x)
                 && (y_ext >= py_ext) && (y_ext < far_y);

        dx     = x_ext - px_ext;
        dy     = y_ext - py_ext;
        tx_raw = dx >> eff_scale;
        ty_raw = dy >> eff_scale;
        tx     = act_mirror_q ? (12'(SPR_W - 1) - tx_raw) : tx_raw;

        tx_a = ADDR_W'(tx);
        ty_a = ADDR_W'(ty_raw);

        in_box_d   = in_box_s0;
        mem_addr_d = in_box_s0 ? (ty_a * ADDR_W'(SPR_W) + tx_a) : '0;
    end

    // in_box delay line: the last stage lines up with mem_rgb for the same
    // pixel, MEM_LAT cycles after mem_addr was issued.
    always_comb begin
        in_box_dly_d    = in_box_dly_q;
        in_box_dly_d[0] = in_box_q;
        for (int i = 1; i < MEM_LAT; i++) begin
            in_box_dly_d[i] = in_box_dly_q[i-1];
        end
    end

    // Output stage: texels matching the key colour are transparent.
    always_comb begin
        hit_d = 1'b0;
        rgb_d = 24'h000000;
        if (in_box_dly_q[MEM_LAT-1] && (mem.mem_rgb != KEY_RGB)) begin
            hit_d = 1'b1;
            rgb_d = mem.mem_rgb;
        end
    end

    // All state. Reset also flushes the pipeline so nothing in flight
    // survives into the restored context.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_pos_x_q   <= 10'(INIT_X);
            sh_pos_y_q   <= 10'(INIT_Y);
            sh_scale_q   <= 2'd0;
            sh_mirror_q  <= 1'b0;
            sh_enable_q  <= 1'b1;
            act_pos_x_q  <= 10'(INIT_X);
            act_pos_y_q  <= 10'(INIT_Y);
            act_scale_q  <= 2'd0;
            act_mirror_q <= 1'b0;
            act_enable_q <= 1'b1;
            mem_addr_q   <= '0;
            in_box_q     <= 1'b0;
            in_box_dly_q <= '0;
            rgb_q        <= 24'h000000;
            hit_q        <= 1'b0;
        end else begin
            sh_pos_x_q   <= sh_pos_x_d;
            sh_pos_y_q   <= sh_pos_y_d;
            sh_scale_q   <= sh_scale_d;
            sh_mirror_q  <= sh_mirror_d;
            sh_enable_q  <= sh_enable_d;
            act_pos_x_q  <= act_pos_x_d;
            act_pos_y_q  <= act_pos_y_d;
            act_scale_q  <= act_scale_d;
            act_mirror_q <= act_mirror_d;
            act_enable_q <= act_enable_d;
            mem_addr_q   <= mem_addr_d;
            in_box_q     <= in_box_d;
            in_box_dly_q <= in_box_dly_d;
            rgb_q        <= rgb_d;
            hit_q        <= hit_d;
        end
    end

    assign mem.mem_addr = mem_addr_q;
    assign VGA_RED      = rgb_q[23:16];
    assign VGA_GREEN    = rgb_q[15:8];
    assign VGA_BLUE     = rgb_q[7:0];
    assign hit          = hit_q;

endmodule

// File: tb/tb_sprite_engine.sv
// ---------------------------------------------------------------------------
// tb_sprite_engine
//
// Scoreboard bench for sprite_engine with the default parameters
// (224x180 sprite, MEM_LAT=1). Every driven coordinate pushes the expected
// mem_addr (due one cycle later) and the expected {hit,RGB} (due three cycles
// later) into queues; a negedge monitor pops and compares them. A small
// behavioural memory returns a texel pattern derived from the address, with
// the key colour at address 5 and 24'h123456 at address 6.
// ---------------------------------------------------------------------------
module tb_sprite_engine;

    localparam int          SPR_W   = 224;
    localparam int          SPR_H   = 180;
    localparam int          ADDR_W  = 16;
    localparam logic [23:0] KEY_RGB = 24'hFF00FF;

    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        frame_start = 1'b0;
    logic        pos_we = 1'b0;
    logic [9:0]  pos_x_in = '0;
    logic [9:0]  pos_y_in = '0;
    logic [1:0]  scale_in = '0;
    logic        mirror_in = 1'b0;
    logic        enable_in = 1'b0;
    logic [7:0]  vga_red, vga_green, vga_blue;
    logic        hit;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t addr_q[$];
    exp_t out_q[$];

    // bench model of shadow and active registers
    int m_sh_px, m_sh_py, m_sh_sc, m_sh_mir, m_sh_en;
    int m_px, m_py, m_sc, m_mir, m_en;

    sprite_engine_if #(.ADDR_W(ADDR_W)) mem_bus ();

    sprite_engine dut (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .y           (y),
        .frame_start (frame_start),
        .pos_we      (pos_we),
        .pos_x_in    (pos_x_in),
        .pos_y_in    (pos_y_in),
        .scale_in    (scale_in),
        .mirror_in   (mirror_in),
        .enable_in   (enable_in),
        .mem         (mem_bus.master),
        .VGA_RED     (vga_red),
        .VGA_GREEN   (vga_green),
        .VGA_BLUE    (vga_blue),
        .hit         (hit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] mem_fn(input logic [15:0] a);
        if (a == 16'd5) return KEY_RGB;
        if (a == 16'd6) return 24'h123456;
        return {a[7:0], a[15:8], 8'hC3};
    endfunction

    // one-cycle-latency sprite memory
    always @(posedge clk) mem_bus.mem_rgb <= mem_fn(mem_bus.mem_addr);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model_pixel(input int sx, input int sy,
                                        output logic ib, output logic [15:0] addr);
        int s, tx, ty;
        s  = (m_sc == 3) ? 2 : m_sc;
        ib = (m_en != 0) && sx >= m_px && sx < m_px + (SPR_W << s)
                         && sy >= m_py && sy < m_py + (SPR_H << s);
        addr = 16'd0;
        if (ib) begin
            tx = (sx - m_px) >> s;
            if (m_mir != 0) tx = SPR_W - 1 - tx;
            ty = (sy - m_py) >> s;
            addr = 16'(ty * SPR_W + tx);
        end
    endfunction

    function automatic void model_reset();
        m_sh_px = 150; m_sh_py = 100; m_sh_sc = 0; m_sh_mir = 0; m_sh_en = 1;
        m_px    = 150; m_py    = 100; m_sc    = 0; m_mir    = 0; m_en    = 1;
    endfunction

    // drive one coordinate for one cycle and queue what it must produce
    task automatic applyStimulus(input int sx, input int sy);
        logic        ib;
        logic [15:0] addr;
        logic [23:0] rgb;
        exp_t        e;
        x = 10'(sx);
        y = 10'(sy);
        model_pixel(sx, sy, ib, addr);
        rgb = mem_fn(addr);
        e.due = cyc + 1;
        e.val = {16'd0, addr};
        addr_q.push_back(e);
        e.due = cyc + 3;
        e.val = (ib && rgb != KEY_RGB) ? {7'd0, 1'b1, rgb} : 32'd0;
        out_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic writeShadow(input int px, input int py, input int sc,
                               input int mir, input int en, input bit commit);
        pos_we      = 1'b1;
        frame_start = commit;
        pos_x_in    = 10'(px);
        pos_y_in    = 10'(py);
        scale_in    = 2'(sc);
        mirror_in   = 1'(mir);
        enable_in   = 1'(en);
        applyStimulus(1023, 1023);
        pos_we      = 1'b0;
        frame_start = 1'b0;
        m_sh_px = px; m_sh_py = py; m_sh_sc = sc; m_sh_mir = mir; m_sh_en = en;
        if (commit) begin
            m_px = px; m_py = py; m_sc = sc; m_mir = mir; m_en = en;
        end
    endtask

    task automatic pulseFrameStart();
        frame_start = 1'b1;
        applyStimulus(1023, 1023);
        frame_start = 1'b0;
        m_px = m_sh_px; m_py = m_sh_py; m_sc = m_sh_sc; m_mir = m_sh_mir; m_en = m_sh_en;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_addr"}, {16'd0, mem_bus.mem_addr}, 32'd0);
        checkOutput({tag, "_pix"}, {7'd0, hit, vga_red, vga_green, vga_blue}, 32'd0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
            e = addr_q.pop_front();
            checkOutput("mem_addr", {16'd0, mem_bus.mem_addr}, e.val);
        end
        while (out_q.size() > 0 && out_q[0].due <= cyc) begin
            e = out_q.pop_front();
            checkOutput("hit_rgb", {7'd0, hit, vga_red, vga_green, vga_blue}, e.val);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;

        // near edge of the reset box
        applyStimulus(149, 100);
        applyStimulus(150, 100);
        applyStimulus(151, 100);
        applyStimulus(150, 99);

        // far edge
        applyStimulus(373, 279);
        applyStimulus(374, 279);
        applyStimulus(373, 280);
        applyStimulus(372, 278);

        // shadow write mid-frame: old box stays until frame_start
        writeShadow(10, 20, 0, 0, 1, 1'b0);
        applyStimulus(150, 100);
        applyStimulus(10, 20);
        pulseFrameStart();
        applyStimulus(10, 20);
        applyStimulus(150, 100);
        applyStimulus(9, 20);

        // 2x scale, mirrored
        writeShadow(150, 100, 1, 1, 1, 1'b0);
        pulseFrameStart();
        applyStimulus(151, 101);
        applyStimulus(150, 100);
        applyStimulus(597, 100);
        applyStimulus(598, 100);
        applyStimulus(150, 459);
        applyStimulus(150, 460);

        // scale code 3 behaves as 4x, written and committed in one cycle
        writeShadow(150, 100, 3, 0, 1, 1'b1);
        applyStimulus(150, 819);
        applyStimulus(150, 820);
        applyStimulus(1023, 100);

        // transparency key and a plain texel
        writeShadow(150, 100, 0, 0, 1, 1'b1);
        applyStimulus(155, 100);
        applyStimulus(156, 100);
        applyStimulus(157, 100);

        // disabled sprite
        writeShadow(150, 100, 0, 0, 0, 1'b1);
        applyStimulus(160, 100);
        writeShadow(10, 20, 0, 0, 1, 1'b1);

        // reset with a hit in flight
        applyStimulus(20, 20);
        addr_q.delete();
        out_q.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkAllZero("rst_flush");
        rst = 1'b0;
        model_reset();
        applyStimulus(150, 100);
        checkOutput("post_rst_0", {7'd0, hit, vga_red, vga_green, vga_blue}, 32'd0);
        applyStimulus(10, 20);
        checkOutput("post_rst_1", {7'd0, hit, vga_red, vga_green, vga_blue}, 32'd0);
        applyStimulus(151, 100);
        repeat (4) applyStimulus(1023, 1023);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("sb_drain", 32'(addr_q.size() + out_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
